gbe_phy_rx_align: RTL and testbench

Parametrised RX PHY adapter for 10/100/1000 Ethernet. It sits between the PHY receive pins (already synchronous to `clk_i`) and the MAC receive logic. It passes GMII bytes straight through, and in MII mode it assembles nibbles into bytes aligned to the SFD rather than to `rx_dv_i` rise. It also detects dribble nibbles and bad preambles and keeps saturating per-event counters.

---
 rtl/gbe_phy_rx_align_if.sv | 22 ++
 rtl/gbe_phy_rx_align.sv | 204 ++++++++++++++++++++
 tb/tb_gbe_phy_rx_align.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/gbe_phy_rx_align_if.sv
// PHY-side receive pins and MAC-side assembled byte stream of the RX aligner.
// The aligner uses the slave modport; the PHY model uses the master modport.
interface gbe_phy_rx_align_if;
  logic       sel_1000m;
  logic [7:0] rx_d;
  logic       rx_dv;
  logic       rx_err;
  logic [7:0] gmii_rx_d;
  logic       gmii_rx_dv;
  logic       gmii_rx_err;
  logic       gmii_rx_eof;

  modport master (
    output sel_1000m, rx_d, rx_dv, rx_err,
    input  gmii_rx_d, gmii_rx_dv, gmii_rx_err, gmii_rx_eof
  );

  modport slave (
    input  sel_1000m, rx_d, rx_dv, rx_err,
    output gmii_rx_d, gmii_rx_dv, gmii_rx_err, gmii_rx_eof
  );
endinterface

// File: rtl/gbe_phy_rx_align.sv
// RX PHY adapter: GMII byte passthrough or SFD-aligned MII nibble assembly,
// with dribble / bad-preamble detection and saturating event counters.
module gbe_phy_rx_align #(
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gbe_phy_rx_align_if.slave    rx,
  output logic                 dribble_o,
  output logic [CNT_W-1:0]     frame_cnt_o,
  output logic [CNT_W-1:0]     dribble_cnt_o,
  output logic [CNT_W-1:0]     bad_pre_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DISCARD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Each stage carries {sel, err, dv, d}; sel travels with the data so the
  // mode is sampled in step with the dv edge it belongs to.
  logic [10:0] pipe_reg [PIPE_STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= {rx.sel_1000m, rx.rx_err, rx.rx_dv, rx.rx_d};
      for (int i = 1; i < PIPE_STAGES; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  logic [7:0] d;
  logic       dv, err, sel;
  assign d   = pipe_reg[PIPE_STAGES-1][7:0];
  assign dv  = pipe_reg[PIPE_STAGES-1][8];
  assign err = pipe_reg[PIPE_STAGES-1][9];
  assign sel = pipe_reg[PIPE_STAGES-1][10];

  state_t     state_reg, state_next;
  logic       mode_reg, mode_next;
  logic       par_reg, par_next;
  logic       pend_reg, pend_next;
  logic [3:0] pend_nib_reg, pend_nib_next;
  logic       pend_err_reg, pend_err_next;
  logic [7:0] out_d_reg, out_d_next;
  logic       out_dv_reg, out_dv_next;
  logic       out_err_reg, out_err_next;
  logic       eof_reg, eof_next;
  logic       dribble_reg, dribble_next;
  logic [CNT_W-1:0] frame_cnt_reg, dribble_cnt_reg, bad_pre_cnt_reg;
  logic       frame_inc, drib_inc, bad_inc;
  logic       pre_nib;
  logic       p_cur;

  // The first MII nibble is handled from IDLE as a preamble nibble with p=0.
  assign p_cur = (state_reg == ST_PRE) && par_reg;

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    par_next      = par_reg;
    pend_next     = pend_reg;
    pend_nib_next = pend_nib_reg;
    pend_err_next = pend_err_reg;
    out_d_next    = out_d_reg;
    out_dv_next   = 1'b0;
    out_err_next  = 1'b0;
    eof_next      = 1'b0;
    dribble_next  = 1'b0;
    frame_inc     = 1'b0;
    drib_inc      = 1'b0;
    bad_inc       = 1'b0;
    pre_nib       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        par_next  = 1'b0;
        pend_next = 1'b0;
        if (dv) begin
          mode_next = sel;
          if (sel) begin
            state_next   = ST_DATA;
            out_dv_next  = 1'b1;
            out_d_next   = d;
            out_err_next = err;
          end else begin
            pre_nib = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (!dv) begin
          state_next = ST_IDLE;
          par_next   = 1'b0;
        end else begin
          pre_nib = 1'b1;
        end
      end
      ST_DATA: begin
        if (dv) begin
          if (mode_reg) begin
            out_dv_next  = 1'b1;
            out_d_next   = d;
            out_err_next = err;
          end else if (pend_reg) begin
            out_dv_next  = 1'b1;
            out_d_next   = {d[3:0], pend_nib_reg};
            out_err_next = err | pend_err_reg;
            pend_next    = 1'b0;
          end else begin
            pend_next     = 1'b1;
            pend_nib_next = d[3:0];
            pend_err_next = err;
          end
        end else begin
          // A leftover nibble at frame end is a dribble nibble and is dropped.
          state_next   = ST_IDLE;
          eof_next     = 1'b1;
          frame_inc    = 1'b1;
          dribble_next = pend_reg & ~mode_reg;
          drib_inc     = pend_reg & ~mode_reg;
          pend_next    = 1'b0;
        end
      end
      ST_DISCARD: begin
        if (!dv) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (pre_nib) begin
      if (d[3:0] == 4'h5) begin
        if (p_cur) begin
          out_dv_next  = 1'b1;
          out_d_next   = 8'h55;
          out_err_next = err;
        end
        par_next   = ~p_cur;
        state_next = ST_PRE;
      end else if (d[3:0] == 4'hD) begin
        // SFD aligns the byte lanes; an unpaired preceding 5 is discarded.
        out_dv_next  = 1'b1;
        out_d_next   = 8'hD5;
        out_err_next = err;
        par_next     = 1'b0;
        pend_next    = 1'b0;
        state_next   = ST_DATA;
      end else begin
        bad_inc    = 1'b1;
        par_next   = 1'b0;
        state_next = ST_DISCARD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= 1'b0;
      par_reg         <= 1'b0;
      pend_reg        <= 1'b0;
      pend_nib_reg    <= 4'h0;
      pend_err_reg    <= 1'b0;
      out_d_reg       <= 8'h00;
      out_dv_reg      <= 1'b0;
      out_err_reg     <= 1'b0;
      eof_reg         <= 1'b0;
      dribble_reg     <= 1'b0;
      frame_cnt_reg   <= '0;
      dribble_cnt_reg <= '0;
      bad_pre_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      par_reg      <= par_next;
      pend_reg     <= pend_next;
      pend_nib_reg <= pend_nib_next;
      pend_err_reg <= pend_err_next;
      out_d_reg    <= out_d_next;
      out_dv_reg   <= out_dv_next;
      out_err_reg  <= out_err_next;
      eof_reg      <= eof_next;
      dribble_reg  <= dribble_next;
      if (frame_inc && frame_cnt_reg != CNT_MAX)
        frame_cnt_reg <= frame_cnt_reg + CNT_ONE;
      if (drib_inc && dribble_cnt_reg != CNT_MAX)
        dribble_cnt_reg <= dribble_cnt_reg + CNT_ONE;
      if (bad_inc && bad_pre_cnt_reg != CNT_MAX)
        bad_pre_cnt_reg <= bad_pre_cnt_reg + CNT_ONE;
    end
  end

  assign rx.gmii_rx_d   = out_d_reg;
  assign rx.gmii_rx_dv  = out_dv_reg;
  assign rx.gmii_rx_err = out_err_reg;
  assign rx.gmii_rx_eof = eof_reg;
  assign dribble_o      = dribble_reg;
  assign frame_cnt_o    = frame_cnt_reg;
  assign dribble_cnt_o  = dribble_cnt_reg;
  assign bad_pre_cnt_o  = bad_pre_cnt_reg;

endmodule

// File: tb/tb_gbe_phy_rx_align.sv
// Directed bench for gbe_phy_rx_align (PIPE_STAGES=2, CNT_W=2): GMII and MII
// frames, odd preamble, dribble, error, bad preamble saturation and reset.
module tb_gbe_phy_rx_align;
  logic       clk = 1'b0;
  logic       rst;
  logic       dribble;
  logic [1:0] frame_cnt, dribble_cnt, bad_pre_cnt;

  gbe_phy_rx_align_if bus ();

  gbe_phy_rx_align #(.PIPE_STAGES(2), .CNT_W(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx            (bus),
    .dribble_o     (dribble),
    .frame_cnt_o   (frame_cnt),
    .dribble_cnt_o (dribble_cnt),
    .bad_pre_cnt_o (bad_pre_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  int t0 = 0;
  int leak = 0;

  logic [7:0] byte_q[$];
  bit         err_q[$];
  int         bcyc_q[$];
  int         eof_q[$];
  int         drib_q[$];
  logic [7:0] stim_d[$];
  bit         stim_e[$];
  logic [7:0] exp_b[$];
  bit         exp_e[$];
  int         exp_o[$];

  // Output recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.gmii_rx_dv) begin
      byte_q.push_back(bus.gmii_rx_d);
      err_q.push_back(bus.gmii_rx_err);
      bcyc_q.push_back(cyc);
    end else if (bus.gmii_rx_err) begin
      leak++;
    end
    if (bus.gmii_rx_eof) eof_q.push_back(cyc);
    if (dribble) drib_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    byte_q.delete(); err_q.delete(); bcyc_q.delete(); eof_q.delete(); drib_q.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic sel);
    bus.sel_1000m = sel; bus.rx_dv = 1'b0; bus.rx_d = 8'h00; bus.rx_err = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    clear_rec();
  endtask

  task automatic add(input logic [7:0] v, input int n, input bit e);
    repeat (n) begin stim_d.push_back(v); stim_e.push_back(e); end
  endtask

  task automatic expb(input logic [7:0] b, input int off, input bit e);
    exp_b.push_back(b); exp_o.push_back(off); exp_e.push_back(e);
  endtask

  // Drives the queued stimulus as one frame, then idles; flips sel at index flip_at.
  task automatic drive_stim(input int flip_at, input bit with_tail);
    t0 = cyc;
    foreach (stim_d[i]) begin
      if (i == flip_at) bus.sel_1000m = ~bus.sel_1000m;
      bus.rx_d = stim_d[i]; bus.rx_dv = 1'b1; bus.rx_err = stim_e[i];
      step();
    end
    stim_d.delete(); stim_e.delete();
    if (with_tail) begin
      bus.rx_d = 8'h00; bus.rx_dv = 1'b0; bus.rx_err = 1'b0;
      repeat (6) step();
    end
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, byte_q.size(), exp_b.size());
    foreach (exp_b[i]) begin
      if (i < byte_q.size()) begin
        chk({tag, "_byte"}, byte_q[i], exp_b[i]);
        chk({tag, "_err"},  err_q[i],  exp_e[i]);
        chk({tag, "_cyc"},  bcyc_q[i] - t0, exp_o[i]);
      end
    end
    exp_b.delete(); exp_o.delete(); exp_e.delete();
  endtask

  task automatic check_eof(input string tag, input int off, input int drib_off);
    chk({tag, "_neof"}, eof_q.size(), 1);
    if (eof_q.size() > 0) chk({tag, "_eofcyc"}, eof_q[0] - t0, off);
    chk({tag, "_ndrib"}, drib_q.size(), (drib_off >= 0) ? 1 : 0);
    if (drib_off >= 0 && drib_q.size() > 0) chk({tag, "_dribcyc"}, drib_q[0] - t0, drib_off);
  endtask

  // 14 preamble 5s, SFD, data nibbles 1,2,3,4 -> bytes at offsets below.
  task automatic exp_even(input bit err21);
    for (int i = 0; i < 7; i++) expb(8'h55, 4 + 2*i, 1'b0);
    expb(8'hD5, 17, 1'b0);
    expb(8'h21, 19, err21);
    expb(8'h43, 21, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus.sel_1000m = 1'b0; bus.rx_d = 8'h00; bus.rx_dv = 1'b0; bus.rx_err = 1'b0;
    repeat (3) step();
    chk("rst_dv", bus.gmii_rx_dv, 1'b0);
    chk("rst_d", bus.gmii_rx_d, 8'h00);
    chk("rst_eof", bus.gmii_rx_eof, 1'b0);
    chk("rst_fcnt", frame_cnt, 2'd0);

    // GMII passthrough; sel flips mid-frame and must be ignored.
    do_reset(1'b1);
    add(8'h55, 7, 1'b0); add(8'hD5, 1, 1'b0); add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0); add(8'h03, 1, 1'b0);
    for (int i = 0; i < 7; i++) expb(8'h55, 3 + i, 1'b0);
    expb(8'hD5, 10, 1'b0); expb(8'h01, 11, 1'b0); expb(8'h02, 12, 1'b0); expb(8'h03, 13, 1'b0);
    drive_stim(5, 1'b1);
    check_bytes("gmii");
    check_eof("gmii", 14, -1);
    chk("gmii_fcnt", frame_cnt, 2'd1);

    // MII even preamble.
    do_reset(1'b0);
    add(8'h05, 14, 1'b0); add(8'h0D, 1, 1'b0);
    add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0); add(8'h03, 1, 1'b0); add(8'h04, 1, 1'b0);
    exp_even(1'b0);
    drive_stim(-1, 1'b1);
    check_bytes("even");
    check_eof("even", 22, -1);
    chk("even_fcnt", frame_cnt, 2'd1);
    chk("even_dcnt", dribble_cnt, 2'd0);

    // MII odd preamble: the 15th 5 is dropped at the SFD.
    do_reset(1'b0);
    add(8'h05, 15, 1'b0); add(8'h0D, 1, 1'b0); add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0);
    for (int i = 0; i < 7; i++) expb(8'h55, 4 + 2*i, 1'b0);
    expb(8'hD5, 18, 1'b0); expb(8'h21, 20, 1'b0);
    drive_stim(-1, 1'b1);
    check_bytes("odd");
    check_eof("odd", 21, -1);
    chk("odd_fcnt", frame_cnt, 2'd1);

    // Dribble nibble F after an even frame.
    do_reset(1'b0);
    add(8'h05, 14, 1'b0); add(8'h0D, 1, 1'b0);
    add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0); add(8'h03, 1, 1'b0); add(8'h04, 1, 1'b0); add(8'h0F, 1, 1'b0);
    exp_even(1'b0);
    drive_stim(-1, 1'b1);
    check_bytes("drib");
    check_eof("drib", 23, 23);
    chk("drib_dcnt", dribble_cnt, 2'd1);
    chk("drib_fcnt", frame_cnt, 2'd1);

    // Error on second data nibble only.
    do_reset(1'b0);
    add(8'h05, 14, 1'b0); add(8'h0D, 1, 1'b0);
    add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b1); add(8'h03, 1, 1'b0); add(8'h04, 1, 1'b0);
    exp_even(1'b1);
    drive_stim(-1, 1'b1);
    check_bytes("err");
    check_eof("err", 22, -1);

    // Bad preamble x5: no output, counter saturates at 3.
    do_reset(1'b0);
    for (int f = 0; f < 5; f++) begin
      add(8'h05, 1, 1'b0); add(8'h0A, 1, 1'b0); add(8'h07, 1, 1'b0);
      drive_stim(-1, 1'b1);
    end
    chk("bad_nbytes", byte_q.size(), 0);
    chk("bad_neof", eof_q.size(), 0);
    chk("bad_cnt", bad_pre_cnt, 2'd3);
    chk("bad_fcnt", frame_cnt, 2'd0);

    // Reset in the middle of a valid frame.
    add(8'h05, 14, 1'b0); add(8'h0D, 1, 1'b0); add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0);
    drive_stim(-1, 1'b0);
    bus.rx_d = 8'h03; bus.rx_dv = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    bus.rx_dv = 1'b0; bus.rx_d = 8'h00;
    chk("mrst_dv", bus.gmii_rx_dv, 1'b0);
    chk("mrst_d", bus.gmii_rx_d, 8'h00);
    chk("mrst_err", bus.gmii_rx_err, 1'b0);
    chk("mrst_eof", bus.gmii_rx_eof, 1'b0);
    chk("mrst_drib", dribble, 1'b0);
    chk("mrst_fcnt", frame_cnt, 2'd0);
    chk("mrst_dcnt", dribble_cnt, 2'd0);
    chk("mrst_bcnt", bad_pre_cnt, 2'd0);
    clear_rec();
    repeat (6) step();
    chk("mrst_nbytes", byte_q.size(), 0);
    chk("mrst_neof", eof_q.size(), 0);

    // Valid frame after reset.
    add(8'h05, 14, 1'b0); add(8'h0D, 1, 1'b0);
    add(8'h01, 1, 1'b0); add(8'h02, 1, 1'b0); add(8'h03, 1, 1'b0); add(8'h04, 1, 1'b0);
    exp_even(1'b0);
    drive_stim(-1, 1'b1);
    check_bytes("post");
    check_eof("post", 22, -1);
    chk("post_fcnt", frame_cnt, 2'd1);

    chk("err_leak", leak, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
